sm_uart_loader: RTL and testbench
=================================

// Module: sm_uart_loader
// PURPOSE
//  Program loader; the write-side counterpart of instruction fetch. Consumes a byte stream
//  from the board UART receiver, parses a framed program image and writes 32-bit words into
//  sm_top instruction memory. Holds the CPU in reset while an image is being loaded.
//  Sits between the UART RX block and the instruction-memory write port in sm_top.
// PARAMETERS
//  ADDR_WIDTH  6        instruction-memory word address width (capacity 2**ADDR_WIDTH words)
//  TIMEOUT     1000000  max clk cycles between bytes inside a frame before abort
// PORTS
//  clk         in   1           system clock
//  rst         in   1           asynchronous reset, active-high
//  rx_data     in   8           received byte
//  rx_valid    in   1           rx_data valid; byte accepted when rx_valid & rx_ready
//  rx_ready    out  1           loader can accept a byte this cycle
//  imem_we     out  1           instruction-memory write strobe (one cycle per word)
//  imem_addr   out  ADDR_WIDTH  word address of the write
//  imem_wdata  out  32          instruction word
//  cpu_hold    out  1           hold CPU in reset (drives sm_top CPU reset logic)
//  busy        out  1           frame in progress (state != IDLE)
//  load_done   out  1           one-cycle pulse: frame accepted, checksum good
//  load_error  out  1           one-cycle pulse: frame aborted
// BEHAVIOUR
//  Frame: 0xA5 | CNT_LO | CNT_HI | CNT words, each 4 bytes little-endian | CSUM.
//  CSUM = XOR of every byte after 0xA5 (count bytes + data bytes).
//  Reset: all outputs 0, state IDLE, address counter 0, checksum acc 0, timer 0.
//  rx_ready = 1 in every state except WRITE; bytes presented in WRITE are held off.
//  States / transitions (one byte consumed per accept):
//   IDLE   : 0xA5 -> CNT_LO, cpu_hold<=1, acc<=0, addr<=0; any other byte discarded.
//   CNT_LO : store low count byte -> CNT_HI.
//   CNT_HI : count==0 -> CSUM; count > 2**ADDR_WIDTH -> ERR; else -> DATA, byte_idx<=0.
//   DATA   : shift byte into word at lane byte_idx; byte_idx==3 -> WRITE, else byte_idx++.
//   WRITE  : imem_we=1 for exactly one cycle with imem_addr=addr, imem_wdata=word;
//            addr++, remaining--; remaining becomes 0 -> CSUM, else -> DATA.
//   CSUM   : byte==acc -> DONE, else -> ERR.
//   DONE   : load_done=1, cpu_hold<=0 -> IDLE (one cycle).
//   ERR    : load_error=1 -> IDLE (one cycle); cpu_hold stays 1 until a later DONE.
//  Latency: imem_we asserts the cycle after the 4th data byte is accepted; load_done the
//   cycle after the CSUM byte is accepted.
//  Timeout: timer clears on every accepted byte and in IDLE; reaching TIMEOUT in any of
//   CNT_LO..CSUM -> ERR. Words already written are not rolled back.
//  Count==2**ADDR_WIDTH is legal; the last word is written at addr all-ones; addr then
//   wraps to 0 and is not used again.
//  0xA5 inside a frame is plain data (no resync).
//  Reset mid-frame: immediate return to reset values, cpu_hold drops to 0.
// STRUCTURE
//  Shared header sm_loader.vh: `LDR_SYNC 8'hA5, state encodings `LDR_IDLE..`LDR_ERR.
//  One sub-module: sm_loader_timer (counter, clear/enable inputs, expired output, TIMEOUT).
//  Byte assembly, checksum and FSM stay in sm_uart_loader.
// TESTING
//  1 Frame A5 01 00 | 78 56 34 12 | CSUM=01^78^56^34^12 -> one imem_we, addr 0,
//    wdata 32'h12345678; load_done pulse; cpu_hold 1 from header accept until DONE.
//  2 Bytes 00 FF A5 00 00 00 -> junk ignored; zero-count frame -> no imem_we, load_done.
//  3 Two-word frame, rx_valid held high continuously -> rx_ready low exactly in the two WRITE
//    cycles, no byte lost, words at addr 0 and 1.
//  4 Wrong CSUM byte -> words written, load_error pulse, cpu_hold stays 1; a following
//    valid frame -> load_done, cpu_hold 0.
//  5 Count 0x0041 with ADDR_WIDTH=6 -> load_error after CNT_HI; count 0x0040 -> 64 writes,
//    last at addr 63.
//  6 TIMEOUT=16, stall after 2 data bytes -> load_error 16 cycles after last accept;
//    assert rst mid-frame -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/sm_uart_loader_pkg.sv
// Shared definitions for the UART program loader: frame sync byte, FSM states
// and a state-class helper used by the top and its frame timer.
package sm_uart_loader_pkg;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } ldr_state_e;

  // States in which a stalled byte stream counts towards the inter-byte timeout.
  function automatic logic in_frame(input ldr_state_e s);
    return s inside {S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_CSUM};
  endfunction

endpackage

// File: rtl/sm_uart_loader_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle whose closing edge is TIMEOUT edges after the clear.
module sm_uart_loader_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && r_count != LIMIT) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/sm_uart_loader.sv
// Program loader: parses A5|CNT_LO|CNT_HI|words(LE)|CSUM from the UART byte stream,
// writes each word into instruction memory and holds the CPU in reset meanwhile.
module sm_uart_loader
  import sm_uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  ldr_state_e            r_state;
  logic                  r_rx_ready;
  logic                  r_imem_we;
  logic                  r_cpu_hold;
  logic                  r_busy;
  logic                  r_load_done;
  logic                  r_load_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_word;
  logic [7:0]            r_acc;
  logic [7:0]            r_cnt_lo;
  logic [15:0]           r_remaining;
  logic [1:0]            r_byte_idx;

  logic                  w_accept;
  logic                  w_expired;
  logic [15:0]           w_count;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_count  = {rx_data, r_cnt_lo};

  sm_uart_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept || (r_state == S_IDLE)),
    .i_enable (in_frame(r_state)),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_addr       <= '0;
      r_word       <= '0;
      r_acc        <= '0;
      r_cnt_lo     <= '0;
      r_remaining  <= '0;
      r_byte_idx   <= '0;
    end else begin
      // NOTE: strobes default low here and are raised only on the edge entering
      // their state; non-blocking updates keep every branch reading pre-edge values.
      r_imem_we    <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_rx_ready   <= 1'b1;

      if (w_expired && !w_accept) begin
        r_state      <= S_ERR;
        r_load_error <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: if (w_accept && rx_data == LDR_SYNC) begin
            r_state    <= S_CNT_LO;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b1;
            r_acc      <= '0;
            r_addr     <= '0;
          end
          S_CNT_LO: if (w_accept) begin
            r_cnt_lo <= rx_data;
            r_acc    <= r_acc ^ rx_data;
            r_state  <= S_CNT_HI;
          end
          S_CNT_HI: if (w_accept) begin
            r_acc       <= r_acc ^ rx_data;
            r_remaining <= w_count;
            r_byte_idx  <= '0;
            if (w_count == 16'd0) begin
              r_state <= S_CSUM;
            end else if ({1'b0, w_count} > DEPTH) begin
              r_state      <= S_ERR;
              r_load_error <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: if (w_accept) begin
            r_word[8*r_byte_idx +: 8] <= rx_data;
            r_acc                     <= r_acc ^ rx_data;
            r_byte_idx                <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state    <= S_WRITE;
              r_imem_we  <= 1'b1;
              r_rx_ready <= 1'b0;
            end
          end
          S_WRITE: begin
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - 16'd1;
            r_state     <= (r_remaining == 16'd1) ? S_CSUM : S_DATA;
          end
          S_CSUM: if (w_accept) begin
            if (rx_data == r_acc) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
            end else begin
              r_state      <= S_ERR;
              r_load_error <= 1'b1;
            end
          end
          S_DONE: begin
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
          // A failed load keeps the CPU held until a later frame completes.
          S_ERR: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_word;
  assign cpu_hold   = r_cpu_hold;
  assign busy       = r_busy;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_sm_uart_loader.sv
// Self-checking bench for sm_uart_loader: directed and random frames scored
// against a frame-level parser model of the expected writes and outcome.
module tb_sm_uart_loader;

  localparam int AW = 6;
  localparam int TO = 16;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          load_done;
  logic          load_error;

  sm_uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle index: bumped on every rising edge, so a value read after edge k is k.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  wr_t  got_w[$];
  int   done_n, err_n, ready_low_n, done_cyc, err_cyc, we_cyc;
  logic hold_at_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        got_w.push_back('{imem_addr, imem_wdata});
        we_cyc = cyc;
      end
      if (load_done) begin
        done_n++;
        done_cyc     = cyc;
        hold_at_done = cpu_hold;
      end
      if (load_error) begin
        err_n++;
        err_cyc = cyc;
      end
      if (!rx_ready) ready_low_n++;
    end
  end

  task automatic clear_mon();
    got_w.delete();
    done_n = 0; err_n = 0; ready_low_n = 0;
    done_cyc = -1; err_cyc = -1; we_cyc = -1;
    hold_at_done = 1'bx;
  endtask

  // Reference model: parse one frame (with optional leading junk) at byte level.
  wr_t  exp_w[$];
  logic exp_done, exp_err;

  task automatic model(input byte_q_t b);
    int   i;
    int   cnt;
    logic [7:0] x;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    i = 0;
    while (i < b.size() && b[i] != 8'hA5) i++;
    cnt = int'({b[i+2], b[i+1]});
    x   = b[i+1] ^ b[i+2];
    if (cnt > 2 ** AW) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < cnt; w++) begin
      int j = i + 3 + 4 * w;
      exp_w.push_back('{AW'(w), {b[j+3], b[j+2], b[j+1], b[j]}});
      x = x ^ b[j] ^ b[j+1] ^ b[j+2] ^ b[j+3];
    end
    if (b[i + 3 + 4 * cnt] == x) exp_done = 1'b1;
    else                         exp_err  = 1'b1;
  endtask

  byte_q_t fr;

  task automatic build(input int n, input bit bad, input int junk);
    logic [7:0] x;
    logic [7:0] v;
    fr.delete();
    for (int k = 0; k < junk; k++) begin
      v = 8'($urandom_range(255, 0));
      fr.push_back((v == 8'hA5) ? 8'h5A : v);
    end
    fr.push_back(8'hA5);
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    x = 8'(n) ^ 8'(n >> 8);
    for (int k = 0; k < 4 * n; k++) begin
      v = 8'($urandom_range(255, 0));
      fr.push_back(v);
      x = x ^ v;
    end
    fr.push_back(bad ? ~x : x);
  endtask

  // Caller is at posedge+1. Leaves rx_valid high so back-to-back bytes stream.
  int last_acc_cyc;

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (rx_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    if (!acc) check("byte_accept_bound", 0, 1);
    last_acc_cyc = cyc;
  endtask

  task automatic run_frame(input string tag, input byte_q_t b, input int gap_max);
    int n;
    model(b);
    clear_mon();
    foreach (b[k]) send_byte(b[k], $urandom_range(gap_max, 0));
    rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("%s.nwr", tag), got_w.size(), exp_w.size());
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s.addr%0d", tag, k), got_w[k].a, exp_w[k].a);
      check($sformatf("%s.data%0d", tag, k), got_w[k].d, exp_w[k].d);
    end
    check($sformatf("%s.done", tag), done_n, exp_done);
    check($sformatf("%s.err", tag), err_n, exp_err);
    check($sformatf("%s.ready_low", tag), ready_low_n, exp_w.size());
    check($sformatf("%s.busy", tag), busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t4;
    int tc;
    byte_q_t t1;

    // Reset state.
    #12;
    check("rst.outputs", {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy,
                          load_done, load_error}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.ready_after", rx_ready, 1);
    check("rst.busy_after", busy, 0);

    // Test 1: single word, with latency and cpu_hold timing.
    clear_mon();
    send_byte(8'hA5, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    check("t1.hold_after_sync", cpu_hold, 1);
    check("t1.busy_after_sync", busy, 1);
    @(posedge clk); #1;
    t1 = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (t1[k]) send_byte(t1[k], 0);
    t4 = last_acc_cyc;
    send_byte(8'h01 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 1);
    tc = last_acc_cyc;
    rx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t1.nwr", got_w.size(), 1);
    if (got_w.size() == 1) begin
      check("t1.addr", got_w[0].a, 0);
      check("t1.data", got_w[0].d, 32'h12345678);
    end
    check("t1.we_latency", we_cyc - t4, 0);
    check("t1.done_n", done_n, 1);
    check("t1.done_latency", done_cyc - tc, 0);
    check("t1.hold_at_done", hold_at_done, 1);
    check("t1.hold_after", cpu_hold, 0);

    // Test 2: junk before a zero-count frame.
    run_frame("t2", '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}, 1);

    // Test 3: two words with rx_valid held high throughout.
    build(2, 0, 0);
    run_frame("t3", fr, 0);

    // Test 4: bad checksum keeps CPU held, a good frame releases it.
    build(2, 1, 0);
    run_frame("t4a", fr, 1);
    check("t4a.hold", cpu_hold, 1);
    build(1, 0, 0);
    run_frame("t4b", fr, 1);
    check("t4b.hold", cpu_hold, 0);

    // Test 5: over-capacity count, then exactly full capacity.
    run_frame("t5a", '{8'hA5, 8'h41, 8'h00}, 0);
    build(64, 0, 0);
    run_frame("t5b", fr, 0);
    if (got_w.size() == 64) check("t5b.last_addr", got_w[63].a, 63);

    // Test 6a: stall after two data bytes triggers the timeout.
    clear_mon();
    t1 = '{8'hA5, 8'h02, 8'h00, 8'hC3, 8'h3C};
    foreach (t1[k]) send_byte(t1[k], 0);
    rx_valid = 1'b0;
    tc = last_acc_cyc;
    for (int i = 0; i < 60 && err_n == 0; i++) @(posedge clk);
    #1;
    check("t6.err_n", err_n, 1);
    check("t6.err_delay", err_cyc - tc, TO);
    check("t6.nwr", got_w.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6.hold", cpu_hold, 1);
    check("t6.busy", busy, 0);

    // Test 6b: reset mid-frame clears every output immediately.
    t1 = '{8'hA5, 8'h03, 8'h00, 8'h11};
    foreach (t1[k]) send_byte(t1[k], 0);
    rx_valid = 1'b0;
    check("t6b.busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6b.outputs", {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy,
                          load_done, load_error}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Random frames: varying length, junk prefix, gaps and corrupted checksums.
    for (int f = 0; f < 15; f++) begin
      build($urandom_range(6, 0), ($urandom_range(3, 0) == 0), $urandom_range(2, 0));
      run_frame($sformatf("rnd%0d", f), fr, 2);
      check($sformatf("rnd%0d.hold", f), cpu_hold, exp_err);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
